assoc_cache: RTL and testbench

Parametrised N-way set-associative cache with multi-word lines. It is the successor to the direct-mapped `cache` and is used as both icache and dcache in front of `imem`/`dmem`.
- Keeps the same CPU-side and memory-side handshake (hit/stall).
- Adds selectable write-back or write-through mode.
- Adds true LRU replacement, a flush command that writes back all dirty lines, and hit/miss counters for CPI analysis.

---
 rtl/cache_pkg.sv | 30 +++
 rtl/lru_update.sv | 54 +++++
 rtl/assoc_cache.sv | 239 +++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache.
//   state_t     : controller states (IDLE, WB, REFILL, FLUSH)
//   field_w     : width of an index field for a power-of-two count (min 1 bit)
//   tag_shift   : bit position of the tag inside a byte address
//   line_meta_t : per-way bookkeeping (valid, dirty, tag, LRU age)
// Tag and age are stored at fixed maximum widths so the struct can live in
// the package; the unused upper bits are always written as zero.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, WB, REFILL, FLUSH} state_t;

  localparam int TAG_MAX_W = 30;
  localparam int AGE_MAX_W = 8;

  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_shift(input int sets, input int line_words);
    return 2 + $clog2(line_words) + $clog2(sets);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_MAX_W-1:0] tag;
    logic [AGE_MAX_W-1:0] age;
  } line_meta_t;

endpackage

// File: rtl/lru_update.sv
// True-LRU helper for one set.
//   age      : current age of every way (0 = most recently used)
//   valid    : valid bit of every way
//   acc_way  : way being accessed this cycle
//   next_age : ages after acc_way becomes most recently used
//   victim   : lowest-index invalid way, else the way whose age is WAYS-1
module lru_update
  import cache_pkg::*;
#(
  parameter int WAYS = 2,
  localparam int WAY_W = field_w(WAYS)
) (
  input  logic [AGE_MAX_W-1:0] age      [WAYS],
  input  logic [WAYS-1:0]      valid,
  input  logic [WAY_W-1:0]     acc_way,
  output logic [AGE_MAX_W-1:0] next_age [WAYS],
  output logic [WAY_W-1:0]     victim
);

  logic [AGE_MAX_W-1:0] acc_age;
  logic                 found;

  // Ways younger than the accessed one age by one; older ways keep their age,
  // so the ages stay a permutation of 0..WAYS-1.
  always_comb begin
    acc_age = age[acc_way];
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == acc_way)
        next_age[w] = '0;
      else if (age[w] < acc_age)
        next_age[w] = age[w] + 1'b1;
      else
        next_age[w] = age[w];
    end
  end

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[w] == AGE_MAX_W'(WAYS - 1))
          victim = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative cache with multi-word lines, true LRU replacement,
// write-back/write-allocate or write-through/no-write-allocate, flush, and
// hit/miss counters.
//   CPU side   : stall, input_ready, addr, write_data, w_en -> hit, read_data
//   flush      : flush pulse in, flush_done pulse out
//   memory side: maddr, mwrite_data, m_wen out; mread_data in (combinational)
//   counters   : hit_count, miss_count (wrap modulo 2^32)
module assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 8,
  parameter int LINE_WORDS = 4,
  parameter bit WRITE_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        input_ready,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        w_en,
  output logic        hit,
  output logic [31:0] read_data,
  input  logic        flush,
  output logic        flush_done,
  output logic [31:0] maddr,
  output logic [31:0] mwrite_data,
  output logic        m_wen,
  input  logic [31:0] mread_data,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int WAY_W  = field_w(WAYS);
  localparam int WRD_W  = field_w(LINE_WORDS);
  localparam int SET_W  = field_w(SETS);
  localparam int TAG_SH = tag_shift(SETS, LINE_WORDS);

  localparam logic [WRD_W-1:0] LAST_WORD = WRD_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);
  localparam logic [SET_W-1:0] LAST_SET  = SET_W'(SETS - 1);

  function automatic logic [31:0] line_addr(input logic [TAG_MAX_W-1:0] tag,
                                            input logic [SET_W-1:0]     idx,
                                            input logic [WRD_W-1:0]     wrd);
    return (32'(tag) << TAG_SH) | (32'(idx) << (2 + OFF_W)) | (32'(wrd) << 2);
  endfunction

  line_meta_t  meta [SETS][WAYS];
  logic [31:0] data [SETS][WAYS][LINE_WORDS];

  state_t               state_q, state_d;
  logic [TAG_MAX_W-1:0] r_tag;
  logic [SET_W-1:0]     r_idx;
  logic [WAY_W-1:0]     r_way;
  logic [WRD_W-1:0]     r_k;
  logic [SET_W-1:0]     f_set;
  logic [WAY_W-1:0]     f_way;

  logic [TAG_MAX_W-1:0] req_tag;
  logic [SET_W-1:0]     req_idx;
  logic [WRD_W-1:0]     req_word;

  logic [AGE_MAX_W-1:0] set_age  [WAYS];
  logic [AGE_MAX_W-1:0] next_age [WAYS];
  logic [WAYS-1:0]      set_valid;
  logic [WAY_W-1:0]     hit_way, victim;
  logic                 any_match, vic_dirty;
  logic                 commit, miss_go, fl_dirty, fl_line_end;
  line_meta_t           fl_meta;

  // Address decode: masks and shifts keep this valid when a field is zero bits wide.
  assign req_word = WRD_W'((addr >> 2) & 32'(LINE_WORDS - 1));
  assign req_idx  = SET_W'((addr >> (2 + OFF_W)) & 32'(SETS - 1));
  assign req_tag  = TAG_MAX_W'(addr >> TAG_SH);

  always_comb begin
    hit_way   = '0;
    any_match = 1'b0;
    set_valid = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_age[w]   = meta[req_idx][w].age;
      set_valid[w] = meta[req_idx][w].valid;
      if (!any_match && meta[req_idx][w].valid && (meta[req_idx][w].tag == req_tag)) begin
        hit_way   = WAY_W'(w);
        any_match = 1'b1;
      end
    end
  end

  lru_update #(.WAYS(WAYS)) u_lru (
    .age      (set_age),
    .valid    (set_valid),
    .acc_way  (hit_way),
    .next_age (next_age),
    .victim   (victim)
  );

  assign vic_dirty   = meta[req_idx][victim].valid & meta[req_idx][victim].dirty;
  assign fl_meta     = meta[f_set][f_way];
  assign fl_dirty    = WRITE_BACK && fl_meta.valid && fl_meta.dirty;
  assign fl_line_end = !fl_dirty || (r_k == LAST_WORD);

  always_comb begin
    state_d     = state_q;
    hit         = 1'b0;
    read_data   = '0;
    maddr       = '0;
    mwrite_data = '0;
    m_wen       = 1'b0;
    flush_done  = 1'b0;
    commit      = 1'b0;
    miss_go     = 1'b0;
    case (state_q)
      IDLE: begin
        // A write-through store always completes in one cycle, hit or miss.
        hit       = input_ready & (any_match | (!WRITE_BACK & w_en));
        read_data = any_match ? data[req_idx][hit_way][req_word] : '0;
        if (!WRITE_BACK && input_ready && w_en && !stall) begin
          m_wen       = 1'b1;
          maddr       = {addr[31:2], 2'b00};
          mwrite_data = write_data;
        end
        commit = hit & ~stall;
        if (flush) begin
          state_d = FLUSH;
        end else if (input_ready && !hit) begin
          miss_go = 1'b1;
          state_d = vic_dirty ? WB : REFILL;
        end
      end
      WB: begin
        m_wen       = 1'b1;
        maddr       = line_addr(meta[r_idx][r_way].tag, r_idx, r_k);
        mwrite_data = data[r_idx][r_way][r_k];
        if (r_k == LAST_WORD) state_d = REFILL;
      end
      REFILL: begin
        maddr = line_addr(r_tag, r_idx, r_k);
        if (r_k == LAST_WORD) state_d = IDLE;
      end
      FLUSH: begin
        if (fl_dirty) begin
          m_wen       = 1'b1;
          maddr       = line_addr(fl_meta.tag, f_set, r_k);
          mwrite_data = data[f_set][f_way][r_k];
        end
        if (fl_line_end && (f_set == LAST_SET) && (f_way == LAST_WAY)) begin
          flush_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and metadata registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      r_tag      <= '0;
      r_idx      <= '0;
      r_way      <= '0;
      r_k        <= '0;
      f_set      <= '0;
      f_way      <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta[s][w] <= '{valid: 1'b0, dirty: 1'b0, tag: '0, age: AGE_MAX_W'(w)};
        end
      end
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (commit) begin
            if (!WRITE_BACK && w_en && !any_match)
              miss_count <= miss_count + 32'd1;
            else
              hit_count <= hit_count + 32'd1;
            if (any_match) begin
              for (int w = 0; w < WAYS; w++) meta[req_idx][w].age <= next_age[w];
              if (WRITE_BACK && w_en) meta[req_idx][hit_way].dirty <= 1'b1;
            end
          end
          if (flush) begin
            f_set <= '0;
            f_way <= '0;
            r_k   <= '0;
          end else if (miss_go) begin
            miss_count <= miss_count + 32'd1;
            r_tag      <= req_tag;
            r_idx      <= req_idx;
            r_way      <= victim;
            r_k        <= '0;
          end
        end
        WB: r_k <= (r_k == LAST_WORD) ? '0 : r_k + 1'b1;
        REFILL: begin
          r_k <= (r_k == LAST_WORD) ? '0 : r_k + 1'b1;
          if (r_k == LAST_WORD) begin
            meta[r_idx][r_way].valid <= 1'b1;
            meta[r_idx][r_way].dirty <= 1'b0;
            meta[r_idx][r_way].tag   <= r_tag;
          end
        end
        FLUSH: begin
          if (fl_line_end) begin
            meta[f_set][f_way].valid <= 1'b0;
            meta[f_set][f_way].dirty <= 1'b0;
            r_k <= '0;
            if (f_way == LAST_WAY) begin
              f_way <= '0;
              f_set <= f_set + 1'b1;
            end else begin
              f_way <= f_way + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line data storage
  always_ff @(posedge clk) begin
    if (commit && any_match && w_en)
      data[req_idx][hit_way][req_word] <= write_data;
    if (state_q == REFILL)
      data[r_idx][r_way][r_k] <= mread_data;
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache: a write-back instance (WAYS=2, SETS=4,
// LINE_WORDS=4) driven from a vector table plus hand sequences for stall,
// flush and mid-refill reset, and a write-through instance.
module tb_assoc_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_init;
  logic        stall, input_ready, w_en, flush;
  logic [31:0] addr, write_data;
  logic        hit, flush_done, m_wen;
  logic [31:0] read_data, maddr, mwrite_data, mread_data, hit_count, miss_count;
  logic [31:0] dmem [64];

  logic        wt_ready, wt_w_en, wt_stall, wt_flush;
  logic [31:0] wt_addr, wt_wdata;
  logic        wt_hit, wt_flush_done, wt_m_wen;
  logic [31:0] wt_read_data, wt_maddr, wt_mwrite_data, wt_mread_data, wt_hit_count, wt_miss_count;
  logic [31:0] dmem_wt [64];

  assign mread_data    = dmem[maddr[7:2]];
  assign wt_mread_data = dmem_wt[wt_maddr[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) begin
        dmem[i]    <= 32'(i);
        dmem_wt[i] <= 32'(i);
      end
    end else begin
      if (m_wen)    dmem[maddr[7:2]]       <= mwrite_data;
      if (wt_m_wen) dmem_wt[wt_maddr[7:2]] <= wt_mwrite_data;
    end
  end

  assoc_cache #(.WAYS(2), .SETS(4), .LINE_WORDS(4), .WRITE_BACK(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .input_ready(input_ready),
    .addr(addr), .write_data(write_data), .w_en(w_en), .hit(hit),
    .read_data(read_data), .flush(flush), .flush_done(flush_done),
    .maddr(maddr), .mwrite_data(mwrite_data), .m_wen(m_wen),
    .mread_data(mread_data), .hit_count(hit_count), .miss_count(miss_count)
  );

  assoc_cache #(.WAYS(2), .SETS(4), .LINE_WORDS(4), .WRITE_BACK(1'b0)) dut_wt (
    .clk(clk), .reset(reset), .stall(wt_stall), .input_ready(wt_ready),
    .addr(wt_addr), .write_data(wt_wdata), .w_en(wt_w_en), .hit(wt_hit),
    .read_data(wt_read_data), .flush(wt_flush), .flush_done(wt_flush_done),
    .maddr(wt_maddr), .mwrite_data(wt_mwrite_data), .m_wen(wt_m_wen),
    .mread_data(wt_mread_data), .hit_count(wt_hit_count), .miss_count(wt_miss_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  logic [31:0] tr_addr [$];
  int          tr_wen;

  // Holds a request until hit (bounded), tracing memory activity meanwhile.
  task automatic do_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd);
    @(negedge clk);
    input_ready = 1'b1; addr = a; w_en = we; write_data = wd;
    tr_addr.delete(); tr_wen = 0; lat = 0;
    #1;
    while (!hit && lat < 40) begin
      tr_addr.push_back(maddr);
      if (m_wen) tr_wen++;
      @(negedge clk); #1;
      lat++;
    end
    rd = read_data;
    @(negedge clk);
    input_ready = 1'b0; w_en = 1'b0; addr = '0; write_data = '0;
    #1;
  endtask

  task automatic wt_access(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd,
                           output logic wen0, output logic [31:0] ma0);
    @(negedge clk);
    wt_ready = 1'b1; wt_addr = a; wt_w_en = we; wt_wdata = wd; lat = 0;
    #1;
    wen0 = wt_m_wen; ma0 = wt_maddr;
    while (!wt_hit && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    rd = wt_read_data;
    @(negedge clk);
    wt_ready = 1'b0; wt_w_en = 1'b0; wt_addr = '0; wt_wdata = '0;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    int          wen;
    logic [31:0] wb_base;
    logic [31:0] rf_base;
    logic [31:0] hits;
    logic [31:0] misses;
  } vec_t;

  vec_t vt [7];

  initial begin
    int          lat, bad, m, wen_n, done_n, hcnt;
    logic [31:0] rd, exp_a, ma0;
    logic        wen0;

    vt[0] = '{32'h48, 1'b0, 32'h0,    5, 32'h12,   0, 32'h0, 32'h40, 32'd1, 32'd1};
    vt[1] = '{32'h4C, 1'b0, 32'h0,    0, 32'h13,   0, 32'h0, 32'h0,  32'd2, 32'd1};
    vt[2] = '{32'h00, 1'b1, 32'hDEAD, 5, 32'h0,    0, 32'h0, 32'h00, 32'd3, 32'd2};
    vt[3] = '{32'h00, 1'b0, 32'h0,    0, 32'hDEAD, 0, 32'h0, 32'h0,  32'd4, 32'd2};
    vt[4] = '{32'h40, 1'b0, 32'h0,    0, 32'h10,   0, 32'h0, 32'h0,  32'd5, 32'd2};
    vt[5] = '{32'h80, 1'b0, 32'h0,    9, 32'h20,   4, 32'h0, 32'h80, 32'd6, 32'd3};
    vt[6] = '{32'h48, 1'b0, 32'h0,    0, 32'h12,   0, 32'h0, 32'h0,  32'd7, 32'd3};

    reset = 1'b1; mem_init = 1'b1;
    stall = 1'b0; input_ready = 1'b0; w_en = 1'b0; flush = 1'b0;
    addr = '0; write_data = '0;
    wt_ready = 1'b0; wt_w_en = 1'b0; wt_stall = 1'b0; wt_flush = 1'b0;
    wt_addr = '0; wt_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; mem_init = 1'b0;
    #1;

    chk("reset hit", {31'b0, hit}, 32'd0);
    chk("reset m_wen", {31'b0, m_wen}, 32'd0);
    chk("reset flush_done", {31'b0, flush_done}, 32'd0);
    chk("reset hit_count", hit_count, 32'd0);
    chk("reset miss_count", miss_count, 32'd0);

    for (int i = 0; i < 7; i++) begin
      do_access(vt[i].a, vt[i].we, vt[i].wd, lat, rd);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vt[i].lat));
      if (!vt[i].we) chk($sformatf("v%0d read_data", i), rd, vt[i].rd);
      chk($sformatf("v%0d m_wen cycles", i), 32'(tr_wen), 32'(vt[i].wen));
      chk($sformatf("v%0d hit_count", i), hit_count, vt[i].hits);
      chk($sformatf("v%0d miss_count", i), miss_count, vt[i].misses);
      if (lat == vt[i].lat && lat > 0) begin
        bad = 0;
        for (int j = 1; j < lat; j++) begin
          m = j - 1;
          if (vt[i].wen > 0 && m < 4) exp_a = vt[i].wb_base + 32'(4 * m);
          else exp_a = vt[i].rf_base + 32'(4 * (m - ((vt[i].wen > 0) ? 4 : 0)));
          if (tr_addr[j] !== exp_a) bad++;
        end
        chk($sformatf("v%0d maddr sequence errors", i), 32'(bad), 32'd0);
      end
      if (i == 2) chk("dmem[0] before writeback", dmem[0], 32'h0);
    end
    chk("dmem[0] after writeback", dmem[0], 32'hDEAD);

    // Store hit held under stall for three cycles.
    @(negedge clk);
    stall = 1'b1; input_ready = 1'b1; addr = 32'h44; w_en = 1'b1; write_data = 32'hBEEF;
    hcnt = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (hit) hcnt++;
      @(negedge clk);
    end
    chk("stalled hit cycles", 32'(hcnt), 32'd3);
    chk("hit_count during stall", hit_count, 32'd7);
    stall = 1'b0;
    #1;
    chk("store hit after release", {31'b0, hit}, 32'd1);
    @(negedge clk);
    input_ready = 1'b0; w_en = 1'b0;
    #1;
    chk("hit_count after stalled store", hit_count, 32'd8);
    do_access(32'h44, 1'b0, 32'h0, lat, rd);
    chk("read back stalled store", rd, 32'hBEEF);
    chk("read back latency", 32'(lat), 32'd0);

    do_access(32'hC4, 1'b1, 32'hCAFE, lat, rd);
    chk("store C4 clean-victim latency", 32'(lat), 32'd5);
    chk("store C4 m_wen cycles", 32'(tr_wen), 32'd0);

    // Flush with two dirty lines in set 0.
    @(negedge clk);
    flush = 1'b1;
    #1;
    wen_n = 0; done_n = 0;
    @(negedge clk);
    flush = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (m_wen) wen_n++;
      if (flush_done) done_n++;
      @(negedge clk);
    end
    chk("flush m_wen cycles", 32'(wen_n), 32'd8);
    chk("flush_done pulses", 32'(done_n), 32'd1);
    chk("dmem[0x11] after flush", dmem[6'h11], 32'hBEEF);
    chk("dmem[0x31] after flush", dmem[6'h31], 32'hCAFE);
    chk("dmem[0x30] after flush", dmem[6'h30], 32'h30);
    do_access(32'h44, 1'b0, 32'h0, lat, rd);
    chk("post-flush 0x44 latency", 32'(lat), 32'd5);
    chk("post-flush 0x44 data", rd, 32'hBEEF);
    do_access(32'hC4, 1'b0, 32'h0, lat, rd);
    chk("post-flush 0xC4 latency", 32'(lat), 32'd5);
    chk("post-flush 0xC4 data", rd, 32'hCAFE);

    // Reset during the second refill cycle.
    apply_reset();
    do_access(32'h04, 1'b0, 32'h0, lat, rd);
    chk("pre-reset 0x04 data", rd, 32'h1);
    @(negedge clk);
    input_ready = 1'b1; addr = 32'h48; w_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("second refill maddr", maddr, 32'h44);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; input_ready = 1'b0; addr = '0;
    #1;
    chk("mid-refill reset m_wen", {31'b0, m_wen}, 32'd0);
    chk("mid-refill reset maddr", maddr, 32'd0);
    chk("mid-refill reset hit_count", hit_count, 32'd0);
    chk("mid-refill reset miss_count", miss_count, 32'd0);
    do_access(32'h48, 1'b0, 32'h0, lat, rd);
    chk("re-read 0x48 latency", 32'(lat), 32'd5);
    chk("re-read 0x48 data", rd, 32'h12);
    chk("re-read 0x48 miss_count", miss_count, 32'd1);
    do_access(32'h04, 1'b0, 32'h0, lat, rd);
    chk("0x04 invalidated by reset", 32'(lat), 32'd5);

    // Write-through instance.
    wt_access(32'h10, 1'b1, 32'h1234ABCD, lat, rd, wen0, ma0);
    chk("wt store miss latency", 32'(lat), 32'd0);
    chk("wt store m_wen", {31'b0, wen0}, 32'd1);
    chk("wt store maddr", ma0, 32'h10);
    chk("wt store miss_count", wt_miss_count, 32'd1);
    chk("wt store hit_count", wt_hit_count, 32'd0);
    chk("wt dmem[4]", dmem_wt[4], 32'h1234ABCD);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (wt_m_wen || wt_maddr != 32'h0) bad++;
      @(negedge clk); #1;
    end
    chk("wt no allocate activity", 32'(bad), 32'd0);
    wt_access(32'h10, 1'b0, 32'h0, lat, rd, wen0, ma0);
    chk("wt read miss latency", 32'(lat), 32'd5);
    chk("wt read data", rd, 32'h1234ABCD);
    wt_access(32'h14, 1'b1, 32'h55, lat, rd, wen0, ma0);
    chk("wt store hit latency", 32'(lat), 32'd0);
    chk("wt store hit maddr", ma0, 32'h14);
    chk("wt store hit hit_count", wt_hit_count, 32'd2);
    chk("wt dmem[5]", dmem_wt[5], 32'h55);
    wt_access(32'h14, 1'b0, 32'h0, lat, rd, wen0, ma0);
    chk("wt updated line data", rd, 32'h55);
    chk("wt updated line latency", 32'(lat), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
